div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Multi-cycle iterative divider with sequencing FSM, sitting beside the EX stage.
- Accepts a DIV/DIVU issued in E and holds the pipeline via `stall_divE` while it iterates.
- Presents quotient/remainder for the HI/LO write path when done.
- `stall_divE` feeds the hazard unit directly; that unit gates `stallF`/`stallD`/`stallE` with it.

Parameters:
- WIDTH, 32, operand/result width; iteration count = WIDTH.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- div_startE  in  1  a DIV/DIVU instruction is in E (level; held while stalled).
- div_signedE  in  1  1 = DIV (signed), 0 = DIVU.
- div_cancel  in  1  flush of E (exception/eret); aborts the operation.
- opaE  in  WIDTH  dividend (rs value after forwarding).
- opbE  in  WIDTH  divisor (rt value after forwarding).
- stall_divE  out  1  hold F/D/E while the operation is in progress.
- div_ready  out  1  one-cycle pulse; results valid this cycle.
- quotient  out  WIDTH  to LO.
- remainder  out  WIDTH  to HI.

Behaviour:
- Reset: state=IDLE; `stall_divE`=0, `div_ready`=0, `quotient`=0, `remainder`=0, counter=0.
- States: IDLE, RUN, ZERO, DONE.
- IDLE:
  - If `div_startE` & ~`div_cancel`: latch |a|, |b| (absolute values only when `div_signedE`, else raw), both sign bits and the signed flag.
  - Next state is ZERO if opbE==0, else RUN with counter=0.
- RUN:
  - One restoring step per cycle: shift partial remainder left, bring in next dividend MSB, trial-subtract divisor, set quotient bit if non-negative.
  - counter++; after WIDTH steps (counter==WIDTH-1 on the edge) go to DONE.
- ZERO: one cycle, then DONE. Result: quotient=all-ones, remainder=opaE as latched (raw, unsigned or signed).
- DONE:
  - `div_ready`=1; `quotient`/`remainder` registered and valid.
  - Signed fixup: quotient negated iff the operand signs differ; remainder takes the dividend's sign.
  - Two's-complement wrap applies: -2^31 / -1 gives quotient 0x8000_0000, remainder 0.
  - Next state is IDLE unconditionally. `div_startE` is ignored in DONE; the instruction leaves E at this edge.
- `stall_divE` (combinational) = ~`div_cancel` & ((IDLE & `div_startE`) | RUN | ZERO). It is 0 in DONE.
- Latency, start sampled in IDLE at T0: RUN covers T1..T32, DONE at T33; `stall_divE` high for T0..T32 (33 cycles). Divide-by-zero: DONE at T2.
- `quotient`/`remainder` hold their last values from DONE until the next DONE; only `div_ready` marks validity.
- Cancel: `div_cancel` in any state forces IDLE at the next edge with no `div_ready` pulse and outputs unchanged. Cancel wins over start in IDLE. Cancel in DONE still lets `div_ready` show this cycle, but the consumer discards it.
- Reset mid-operation behaves exactly like reset from idle.
- Back-to-back: a second start can be accepted in the IDLE cycle directly after DONE.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in IDLE, if opbE!=0 and |a| < |b| (unsigned compare of the latched magnitudes), go to ZERO-style single-cycle path, then DONE with quotient=0 and remainder=opaE (raw). `stall_divE` is high for T0..T1; DONE at T2.
- Undefined: every nonzero divisor takes the full WIDTH-cycle RUN.

Test Plan:
- Unsigned 100/7 (`div_signedE`=0) -> `stall_divE` high 33 cycles, `div_ready` at T33, quotient=14, remainder=2.
- Signed -7/2 (0xFFFFFFF9/0x2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Then 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
- Divide by zero, opaE=0x1234, opbE=0 -> `div_ready` at T2, quotient=0xFFFFFFFF, remainder=0x1234.
- `div_cancel` asserted at T10 of RUN -> `stall_divE` drops at T10, IDLE at T11, no `div_ready`, outputs keep prior values. A new start at T11 completes normally.
- Overflow and back-to-back: -2^31/-1 -> quotient=0x80000000, remainder=0. The next start in the cycle after DONE is accepted and gives 50/5 -> quotient=10, remainder=0. Assert `rst` mid-RUN -> all outputs 0 next cycle.
- DIV_EARLY_EXIT_EN: 3/10 -> `div_ready` at T2, quotient=0, remainder=3. Without the macro: `div_ready` at T33, same result.

Source files
------------

// File: rtl/div_ctrl.sv
// Iterative restoring divider beside the EX stage: holds F/D/E via stall_divE while it iterates.
// Optional DIV_EARLY_EXIT_EN: a dividend magnitude smaller than the divisor finishes in two cycles.
module div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_startE,
    input  logic             div_signedE,
    input  logic             div_cancel,
    input  logic [WIDTH-1:0] opaE,
    input  logic [WIDTH-1:0] opbE,
    output logic             stall_divE,
    output logic             div_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {IDLE, RUN, ZERO, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] dvd_reg, dvd_next;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_reg, dvs_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] raw_a_reg, raw_a_next;
    logic             sign_a_reg, sign_a_next;
    logic             sign_b_reg, sign_b_next;
    logic             signed_reg, signed_next;
    logic             by_zero_reg, by_zero_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   trial;
    logic             step_ok;
    logic [WIDTH-1:0] step_rem, step_quo, fix_q, fix_r;

    assign abs_a = (div_signedE && opaE[WIDTH-1]) ? -opaE : opaE;
    assign abs_b = (div_signedE && opbE[WIDTH-1]) ? -opbE : opbE;

    // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
    assign trial    = {rem_reg, dvd_reg[WIDTH-1]} - {1'b0, dvs_reg};
    assign step_ok  = ~trial[WIDTH];
    assign step_rem = step_ok ? trial[WIDTH-1:0] : {rem_reg[WIDTH-2:0], dvd_reg[WIDTH-1]};
    assign step_quo = {dvd_reg[WIDTH-2:0], step_ok};

    // Quotient negative on differing signs; remainder follows the dividend sign.
    assign fix_q = (signed_reg && (sign_a_reg ^ sign_b_reg)) ? -step_quo : step_quo;
    assign fix_r = (signed_reg && sign_a_reg) ? -step_rem : step_rem;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        dvd_next       = dvd_reg;
        dvs_next       = dvs_reg;
        rem_next       = rem_reg;
        raw_a_next     = raw_a_reg;
        sign_a_next    = sign_a_reg;
        sign_b_next    = sign_b_reg;
        signed_next    = signed_reg;
        by_zero_next   = by_zero_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        case (state_reg)
            IDLE: begin
                if (div_startE) begin
                    dvd_next     = abs_a;
                    dvs_next     = abs_b;
                    rem_next     = '0;
                    raw_a_next   = opaE;
                    sign_a_next  = div_signedE & opaE[WIDTH-1];
                    sign_b_next  = div_signedE & opbE[WIDTH-1];
                    signed_next  = div_signedE;
                    cnt_next     = '0;
                    by_zero_next = 1'b0;
                    if (opbE == '0) begin
                        by_zero_next = 1'b1;
                        state_next   = ZERO;
                    end
`ifdef DIV_EARLY_EXIT_EN
                    else if (abs_a < abs_b) begin
                        state_next = ZERO;
                    end
`endif
                    else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                dvd_next = step_quo;
                rem_next = step_rem;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next     = DONE;
                    quotient_next  = fix_q;
                    remainder_next = fix_r;
                end
            end
            ZERO: begin
                state_next     = DONE;
                quotient_next  = by_zero_reg ? '1 : '0;
                remainder_next = raw_a_reg;
            end
            default: state_next = IDLE;
        endcase
        // A flush aborts whatever is in flight and leaves the visible results untouched.
        if (div_cancel) begin
            state_next     = IDLE;
            quotient_next  = quotient_reg;
            remainder_next = remainder_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            rem_reg       <= '0;
            raw_a_reg     <= '0;
            sign_a_reg    <= 1'b0;
            sign_b_reg    <= 1'b0;
            signed_reg    <= 1'b0;
            by_zero_reg   <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            dvd_reg       <= dvd_next;
            dvs_reg       <= dvs_next;
            rem_reg       <= rem_next;
            raw_a_reg     <= raw_a_next;
            sign_a_reg    <= sign_a_next;
            sign_b_reg    <= sign_b_next;
            signed_reg    <= signed_next;
            by_zero_reg   <= by_zero_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
        end
    end

    assign stall_divE = ~div_cancel & (((state_reg == IDLE) & div_startE) |
                                       (state_reg == RUN) | (state_reg == ZERO));
    assign div_ready  = (state_reg == DONE);
    assign quotient   = quotient_reg;
    assign remainder  = remainder_reg;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed table-driven bench for div_ctrl: latency, stall length, results, cancel and reset cases.
module tb_div_ctrl;

`ifdef DIV_EARLY_EXIT_EN
    localparam int LAT_SMALL = 2;
`else
    localparam int LAT_SMALL = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        div_startE, div_signedE, div_cancel;
    logic [31:0] opaE, opbE;
    logic        stall_divE, div_ready;
    logic [31:0] quotient, remainder;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_startE (div_startE),
        .div_signedE(div_signedE),
        .div_cancel (div_cancel),
        .opaE       (opaE),
        .opbE       (opbE),
        .stall_divE (stall_divE),
        .div_ready  (div_ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Starts an operation in the current cycle and follows it to the ready pulse.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int elat);
        int  stalls;
        int  lat;
        bit  done;
        div_signedE = sgn;
        opaE        = a;
        opbE        = b;
        div_startE  = 1'b1;
        #1;
        chk("ready_at_t0", {31'b0, div_ready}, 32'd0);
        stalls = stall_divE ? 1 : 0;
        lat    = 0;
        done   = 1'b0;
        for (int c = 1; c <= 100 && !done; c++) begin
            @(posedge clk);
            #1;
            if (div_ready) begin
                done = 1'b1;
                lat  = c;
            end else if (stall_divE) begin
                stalls++;
            end
        end
        div_startE = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout actual=no_ready required=ready_within_100");
        end else begin
            chk("stall_in_done", {31'b0, stall_divE}, 32'd0);
            chk("latency", lat, elat);
            chk("stall_cycles", stalls, elat);
            chk("quotient", quotient, eq);
            chk("remainder", remainder, er);
        end
        $display("op s=%0d a=%08h b=%08h -> q=%08h r=%08h lat=%0d stalls=%0d", sgn, a, b,
                 quotient, remainder, lat, stalls);
    endtask

    initial begin
        logic [31:0] prev_q, prev_r;
        bit          saw_ready;

        vecs[0] = '{1'b0, 32'd100,       32'd7,          32'd14,         32'd2,          33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'h2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33};
        vecs[2] = '{1'b1, 32'h7,         32'hFFFFFFFE,   32'hFFFFFFFD,   32'h1,          33};
        vecs[3] = '{1'b0, 32'h1234,      32'h0,          32'hFFFFFFFF,   32'h1234,       2};
        vecs[4] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   32'h0,          33};
        vecs[5] = '{1'b0, 32'd50,        32'd5,          32'd10,         32'd0,          33};
        vecs[6] = '{1'b0, 32'd3,         32'd10,         32'd0,          32'd3,          LAT_SMALL};
        vecs[7] = '{1'b0, 32'hFFFFFFFF,  32'h1,          32'hFFFFFFFF,   32'h0,          33};
        vecs[8] = '{1'b1, 32'hFFFFFF9C,  32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   33};
        vecs[9] = '{1'b0, 32'hFFFFFFFF,  32'h10,         32'h0FFFFFFF,   32'hF,          33};

        rst = 1'b1; div_startE = 1'b0; div_signedE = 1'b0; div_cancel = 1'b0;
        opaE = '0; opbE = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", {31'b0, stall_divE}, 32'd0);
        chk("reset_ready", {31'b0, div_ready}, 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        rst = 1'b0;

        // Each vector starts in the IDLE cycle right after the previous DONE.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat);
        end

        // Cancel at T10 of RUN, then a fresh start at T11.
        @(posedge clk);
        #1;
        prev_q = quotient;
        prev_r = remainder;
        div_signedE = 1'b0; opaE = 32'd100; opbE = 32'd7; div_startE = 1'b1;
        saw_ready = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (div_ready) saw_ready = 1'b1;
        end
        div_cancel = 1'b1;
        #1;
        chk("cancel_stall_drop", {31'b0, stall_divE}, 32'd0);
        @(posedge clk);
        #1;
        div_cancel = 1'b0;
        if (div_ready) saw_ready = 1'b1;
        chk("cancel_no_ready", {31'b0, saw_ready}, 32'd0);
        chk("cancel_q_hold", quotient, prev_q);
        chk("cancel_r_hold", remainder, prev_r);
        $display("op cancel at T10 q=%08h r=%08h", quotient, remainder);
        run_op(1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 33);

        // Cancel beats start in IDLE: the operation must never be accepted.
        @(posedge clk);
        #1;
        div_signedE = 1'b0; opaE = 32'd100; opbE = 32'd7;
        div_startE = 1'b1; div_cancel = 1'b1;
        #1;
        chk("cancel_start_stall", {31'b0, stall_divE}, 32'd0);
        @(posedge clk);
        #1;
        div_startE = 1'b0; div_cancel = 1'b0;
        saw_ready = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (div_ready || stall_divE) saw_ready = 1'b1;
        end
        chk("cancel_start_ignored", {31'b0, saw_ready}, 32'd0);
        $display("op cancel+start in IDLE activity=%0d", saw_ready);

        // Reset in the middle of RUN clears everything.
        @(posedge clk);
        #1;
        div_signedE = 1'b0; opaE = 32'd100; opbE = 32'd7; div_startE = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; div_startE = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_rst_quotient", quotient, 32'd0);
        chk("midrun_rst_remainder", remainder, 32'd0);
        chk("midrun_rst_ready", {31'b0, div_ready}, 32'd0);
        chk("midrun_rst_stall", {31'b0, stall_divE}, 32'd0);
        $display("op reset mid-RUN q=%08h r=%08h", quotient, remainder);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
